imem_loader: RTL

- Byte-stream writer that fills the instruction memory before the single-cycle core is released to fetch from it.
- Receives a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to consecutive instruction-memory word addresses, holding the core in reset until loading completes.
- On completion, releases the core's reset and issues the one-cycle `start` pulse that launches fetch.

---
 rtl/imem_loader.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Fills the instruction memory before the single-cycle core starts fetching.
// A length-prefixed byte stream arrives over a valid/ready handshake:
//   N_lo, N_hi, then 4*N instruction bytes, least-significant byte first.
// Bytes are packed into little-endian 32-bit words. Each word goes to the
// next instruction-memory word address. The core is held in reset for the
// whole load. When the load finishes, the core's reset is released and a
// one-cycle start pulse launches fetch.
//
// Parameters
//   ADDR_W        instruction-memory word-address width (2**ADDR_W words)
//
// Ports
//   clk           system clock, rising-edge active
//   reset         synchronous, active-high reset
//   load_req      begin a new load (honoured in IDLE, DONE and ERR only)
//   rx_valid      byte source presents a byte on rx_data
//   rx_data       stream byte
//   rx_ready      loader takes the byte this cycle (HDR0, HDR1, DATA)
//   imem_we       instruction-memory write strobe (WRITE state)
//   imem_addr     word address of the write
//   imem_wdata    assembled instruction word
//   core_reset    reset hold for the core, low only in DONE
//   start         one-cycle pulse on the first DONE cycle
//   busy          high in HDR0, HDR1, DATA, WRITE
//   done          high in DONE
//   error         high in ERR (word count exceeds memory capacity)
//   words_loaded  words written in the current load
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    // Memory capacity in words, widened so that a 16-bit N can be compared
    // against it without overflow for any ADDR_W up to 16.
    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              start_q, start_d;

    logic              accept;
    logic              load_start;
    logic [15:0]       n_full;
    logic              n_too_big;
    logic              last_word;

    // A byte moves only when the source offers it and the state decode says
    // the loader is listening.
    assign accept = rx_valid && rx_ready;

    // A new load may only begin from a resting state.
    assign load_start = load_req &&
                        ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));

    // Full word count as it will be once the high header byte is captured.
    assign n_full    = {rx_data, n_q[7:0]};
    assign n_too_big = ({1'b0, n_full} > CAPACITY);

    // True while writing the final word of this load.
    assign last_word = ((17'(words_q) + 17'd1) == {1'b0, n_q});

    // -------------------------------------------------------------------------
    // State register and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: reset is synchronous here, so it lives inside the clocked branch
    // and is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q    <= S_IDLE;
            n_q        <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            words_q    <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            words_q    <= words_d;
            start_q    <= start_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // which prevents latch inference.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_req) state_d = S_HDR0;
            end
            S_HDR0: begin
                if (accept) state_d = S_HDR1;
            end
            S_HDR1: begin
                if (accept) begin
                    if (n_full == 16'd0) state_d = S_DONE;
                    else if (n_too_big)  state_d = S_ERR;
                    else                 state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && (byte_cnt_q == 2'd3)) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = last_word ? S_DONE : S_DATA;
            end
            S_DONE, S_ERR: begin
                if (load_req) state_d = S_HDR0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        n_d        = n_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        words_d    = words_q;

        // start is high for the first cycle spent in DONE only.
        start_d = (state_d == S_DONE) && (state_q != S_DONE);

        if (load_start) begin
            n_d        = '0;
            byte_cnt_d = '0;
            words_d    = '0;
            addr_d     = '0;
        end

        case (state_q)
            S_HDR0: begin
                if (accept) n_d[7:0] = rx_data;
            end
            S_HDR1: begin
                if (accept) n_d[15:8] = rx_data;
            end
            S_DATA: begin
                if (accept) begin
                    // Little-endian packing: the byte count is the lane index.
                    wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
            end
            S_WRITE: begin
                words_d = words_q + (ADDR_W+1)'(1);
                // Holding the address on the final word keeps a full-capacity
                // load from wrapping imem_addr back to 0.
                if (!last_word) addr_d = addr_q + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (state register only)
    // -------------------------------------------------------------------------
    always_comb begin
        rx_ready   = 1'b0;
        imem_we    = 1'b0;
        core_reset = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
            end
            S_DONE: begin
                core_reset = 1'b0;
                done       = 1'b1;
            end
            S_ERR: begin
                error = 1'b1;
            end
            default: ;
        endcase
    end

    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;
    assign start        = start_q;

endmodule
